// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debounce block.
package switch_debounce_pkg;

   // 1 ms tick at a 50 MHz system clock.
   localparam int DEF_TICK_DIV     = 50000;
   // Number of consecutive ticks a new level must persist.
   localparam int DEF_STABLE_TICKS = 10;
   // Per-bit qualification counter width; covers STABLE_TICKS up to 15.
   localparam int CNT_W            = 4;

   // Bits needed to hold the values 0..value-1, i.e. ceil(log2(value)).
   // A minimum of 1 keeps the prescaler width legal at the low end.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage : switch_debounce_pkg

// File: rtl/switch_debounce_bit.sv
// Single-bit switch conditioner: two-flop synchroniser, tick-qualified
// stability counter, clean level flop and registered rise/fall pulses.
module debounce_bit
   import switch_debounce_pkg::*;
#(
   parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic RESET_VAL    = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick_i,
   input  logic raw_i,
   output logic clean_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             clean_q;
   logic             clean_d;
   logic             rise_q;
   logic             rise_d;
   logic             fall_q;
   logic             fall_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Bring the raw pin into the clk domain; only sync2 is used downstream.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Qualification: any agreement with the clean level restarts the count,
   // otherwise each tick advances it until the new level is accepted.
   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q == clean_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == CNT_LAST) begin
            clean_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter, clean level and edge pulses; pulses coincide with the first
   // cycle the new clean level is visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         clean_q <= RESET_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign clean_o = clean_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule : debounce_bit

// File: rtl/switch_debounce.sv
// Slide-switch conditioner feeding the switch PIO in_port: shared
// prescaler tick, one debounce_bit per switch, aggregate change strobe.
module switch_debounce
   import switch_debounce_pkg::*;
#(
   parameter int               WIDTH        = 18,
   parameter int               TICK_DIV     = DEF_TICK_DIV,
   parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_change
);

   localparam int             PRE_W    = clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic             tick;

   assign tick = (pre_q == PRE_LAST);

   // Free-running prescaler, wraps after the tick cycle.
   always_comb begin
      pre_d = pre_q + 1'b1;
      if (tick) begin
         pre_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS),
         .RESET_VAL    (RESET_VAL[i])
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .tick_i  (tick),
         .raw_i   (sw_raw[i]),
         .clean_o (sw_clean[i]),
         .rise_o  (sw_rise[i]),
         .fall_o  (sw_fall[i])
      );
   end

   // Pulses are already registered, so the strobe lines up with them.
   assign sw_change = |(sw_rise | sw_fall);

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_switch_debounce;

   logic        clk;
   logic        reset_n;
   logic [17:0] sw_raw;
   logic [17:0] sw_clean;
   logic [17:0] sw_rise;
   logic [17:0] sw_fall;
   logic        sw_change;

   int checks;
   int failures;

   // Observation results (recorded only, compared inside each test).
   int          obs_clean_cyc;
   int          obs_pulse_cyc;
   int          obs_npulse;
   int          obs_chg_err;
   int          obs_both_err;
   logic [17:0] obs_rise;
   logic [17:0] obs_fall;

   switch_debounce #(
      .WIDTH        (18),
      .TICK_DIV     (4),
      .STABLE_TICKS (3),
      .RESET_VAL    (18'h0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw_raw    (sw_raw),
      .sw_clean  (sw_clean),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
      .sw_change (sw_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Watch ncyc rising edges, sampling 1 time unit after each edge.
   task automatic observe(input int ncyc);
      logic [17:0] prev;
      prev          = sw_clean;
      obs_clean_cyc = 0;
      obs_pulse_cyc = 0;
      obs_npulse    = 0;
      obs_chg_err   = 0;
      obs_both_err  = 0;
      obs_rise      = '0;
      obs_fall      = '0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         #1;
         if (sw_clean !== prev && obs_clean_cyc == 0) obs_clean_cyc = c;
         prev = sw_clean;
         if ((sw_rise | sw_fall) != 18'h0) begin
            obs_npulse++;
            if (obs_pulse_cyc == 0) begin
               obs_pulse_cyc = c;
               obs_rise      = sw_rise;
               obs_fall      = sw_fall;
            end
         end
         if (sw_change !== (|(sw_rise | sw_fall))) obs_chg_err++;
         if ((sw_rise & sw_fall) != 18'h0) obs_both_err++;
      end
   endtask

   task automatic test_reset();
      sw_raw  = 18'h3FFFF;
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (sw_clean !== 18'h0) begin
            failures++;
            $display("FAIL reset_clean got=%h want=00000", sw_clean);
         end
         checks++;
         if (sw_rise !== 18'h0 || sw_fall !== 18'h0 || sw_change !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses got rise=%h fall=%h chg=%b want 0", sw_rise, sw_fall, sw_change);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      observe(30);
      checks++;
      if (obs_clean_cyc < 11 || obs_clean_cyc > 14) begin
         failures++;
         $display("FAIL reset_latency got=%0d want=11..14", obs_clean_cyc);
      end
      checks++;
      if (obs_pulse_cyc !== obs_clean_cyc) begin
         failures++;
         $display("FAIL reset_pulse_align got=%0d want=%0d", obs_pulse_cyc, obs_clean_cyc);
      end
      checks++;
      if (obs_rise !== 18'h3FFFF || obs_fall !== 18'h0) begin
         failures++;
         $display("FAIL reset_rise got rise=%h fall=%h want rise=3ffff fall=0", obs_rise, obs_fall);
      end
      checks++;
      if (obs_npulse !== 1 || obs_chg_err !== 0) begin
         failures++;
         $display("FAIL reset_single_pulse got n=%0d chgerr=%0d want n=1 chgerr=0", obs_npulse, obs_chg_err);
      end
      checks++;
      if (sw_clean !== 18'h3FFFF) begin
         failures++;
         $display("FAIL reset_final got=%h want=3ffff", sw_clean);
      end
      // Return all switches low for the following scenarios.
      @(negedge clk);
      sw_raw = 18'h0;
      observe(30);
      checks++;
      if (obs_fall !== 18'h3FFFF || obs_rise !== 18'h0 || obs_npulse !== 1 || sw_clean !== 18'h0) begin
         failures++;
         $display("FAIL all_fall got fall=%h rise=%h n=%0d clean=%h want fall=3ffff rise=0 n=1 clean=0",
                  obs_fall, obs_rise, obs_npulse, sw_clean);
      end
   endtask

   task automatic test_clean_step();
      @(negedge clk);
      sw_raw[0] = 1'b1;
      observe(30);
      checks++;
      if (obs_clean_cyc < 11 || obs_clean_cyc > 14) begin
         failures++;
         $display("FAIL step_latency got=%0d want=11..14", obs_clean_cyc);
      end
      checks++;
      if (obs_rise !== 18'h1 || obs_fall !== 18'h0 || obs_pulse_cyc !== obs_clean_cyc) begin
         failures++;
         $display("FAIL step_pulse got rise=%h fall=%h at=%0d want rise=00001 fall=0 at=%0d",
                  obs_rise, obs_fall, obs_pulse_cyc, obs_clean_cyc);
      end
      checks++;
      if (obs_npulse !== 1 || obs_chg_err !== 0 || sw_clean !== 18'h1) begin
         failures++;
         $display("FAIL step_final got n=%0d chgerr=%0d clean=%h want n=1 chgerr=0 clean=00001",
                  obs_npulse, obs_chg_err, sw_clean);
      end
   endtask

   task automatic test_bounce();
      int bounce_pulses;
      int bounce_changes;
      bounce_pulses  = 0;
      bounce_changes = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         sw_raw[5] = (k % 2 == 0);
         observe(3);
         bounce_pulses  += obs_npulse;
         bounce_changes += (obs_clean_cyc != 0) ? 1 : 0;
      end
      checks++;
      if (bounce_pulses !== 0 || bounce_changes !== 0 || sw_clean !== 18'h1) begin
         failures++;
         $display("FAIL bounce_reject got pulses=%0d changes=%0d clean=%h want 0 0 00001",
                  bounce_pulses, bounce_changes, sw_clean);
      end
      @(negedge clk);
      sw_raw[5] = 1'b1;
      observe(30);
      checks++;
      if (obs_clean_cyc < 11 || obs_clean_cyc > 14) begin
         failures++;
         $display("FAIL bounce_latency got=%0d want=11..14", obs_clean_cyc);
      end
      checks++;
      if (obs_rise !== 18'h20 || obs_fall !== 18'h0 || obs_npulse !== 1 || sw_clean !== 18'h21) begin
         failures++;
         $display("FAIL bounce_pulse got rise=%h fall=%h n=%0d clean=%h want rise=00020 fall=0 n=1 clean=00021",
                  obs_rise, obs_fall, obs_npulse, sw_clean);
      end
   endtask

   task automatic test_glitch();
      int glitch_pulses;
      int glitch_changes;
      @(negedge clk);
      sw_raw[17] = 1'b1;
      observe(6);
      glitch_pulses  = obs_npulse;
      glitch_changes = (obs_clean_cyc != 0) ? 1 : 0;
      @(negedge clk);
      sw_raw[17] = 1'b0;
      observe(30);
      glitch_pulses  += obs_npulse;
      glitch_changes += (obs_clean_cyc != 0) ? 1 : 0;
      checks++;
      if (glitch_pulses !== 0 || glitch_changes !== 0 || sw_clean !== 18'h21) begin
         failures++;
         $display("FAIL glitch_reject got pulses=%0d changes=%0d clean=%h want 0 0 00021",
                  glitch_pulses, glitch_changes, sw_clean);
      end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      sw_raw[3] = 1'b1;
      observe(30);
      checks++;
      if (obs_rise !== 18'h8 || obs_npulse !== 1 || sw_clean !== 18'h29) begin
         failures++;
         $display("FAIL simul_presettle got rise=%h n=%0d clean=%h want rise=00008 n=1 clean=00029",
                  obs_rise, obs_npulse, sw_clean);
      end
      @(negedge clk);
      sw_raw[2] = 1'b1;
      sw_raw[3] = 1'b0;
      observe(30);
      checks++;
      if (obs_rise !== 18'h4 || obs_fall !== 18'h8) begin
         failures++;
         $display("FAIL simul_edges got rise=%h fall=%h want rise=00004 fall=00008", obs_rise, obs_fall);
      end
      checks++;
      if (obs_npulse !== 1 || obs_chg_err !== 0 || obs_both_err !== 0) begin
         failures++;
         $display("FAIL simul_change got n=%0d chgerr=%0d both=%0d want 1 0 0", obs_npulse, obs_chg_err, obs_both_err);
      end
      checks++;
      if (obs_clean_cyc < 11 || obs_clean_cyc > 14 || sw_clean !== 18'h25) begin
         failures++;
         $display("FAIL simul_final got lat=%0d clean=%h want 11..14 clean=00025", obs_clean_cyc, sw_clean);
      end
   endtask

   task automatic test_reset_mid_count();
      @(negedge clk);
      sw_raw[7] = 1'b1;
      // Six edges puts the bit past its first tick but short of its second.
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (sw_clean !== 18'h0 || sw_rise !== 18'h0 || sw_fall !== 18'h0 || sw_change !== 1'b0) begin
         failures++;
         $display("FAIL midrst_clear got clean=%h rise=%h fall=%h chg=%b want all 0",
                  sw_clean, sw_rise, sw_fall, sw_change);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      observe(30);
      checks++;
      if (obs_clean_cyc < 11 || obs_clean_cyc > 14) begin
         failures++;
         $display("FAIL midrst_latency got=%0d want=11..14", obs_clean_cyc);
      end
      checks++;
      if (obs_rise !== 18'hA5 || obs_fall !== 18'h0 || obs_npulse !== 1 || sw_clean !== 18'hA5) begin
         failures++;
         $display("FAIL midrst_requal got rise=%h fall=%h n=%0d clean=%h want rise=000a5 fall=0 n=1 clean=000a5",
                  obs_rise, obs_fall, obs_npulse, sw_clean);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      sw_raw   = 18'h0;
      test_reset();
      test_clean_step();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_reset_mid_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_switch_debounce
